// File: rtl/reorder_buffer_pkg.sv
// ----------------------------------------------------------------------------
// reorder_buffer_pkg
//   Shared LC-3b types used by the reorder buffer and its neighbours.
//   Provides the opcode enum, the register index type, the ROB tag type and
//   a packed ROB entry record for stages that want to carry a whole entry.
//   No ports; import with "import reorder_buffer_pkg::*;".
// ----------------------------------------------------------------------------
package reorder_buffer_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int TAG_WIDTH  = 3;
    localparam int ROB_DEPTH  = 1 << TAG_WIDTH;

    // LC-3b opcode field, bits [15:12] of the instruction word
    typedef enum logic [3:0] {
        op_br   = 4'd0,
        op_add  = 4'd1,
        op_ldb  = 4'd2,
        op_stb  = 4'd3,
        op_jsr  = 4'd4,
        op_and  = 4'd5,
        op_ldr  = 4'd6,
        op_str  = 4'd7,
        op_rti  = 4'd8,
        op_not  = 4'd9,
        op_ldi  = 4'd10,
        op_sti  = 4'd11,
        op_jmp  = 4'd12,
        op_shf  = 4'd13,
        op_lea  = 4'd14,
        op_trap = 4'd15
    } lc3b_opcode;

    // Register index; for branches this field carries the nzp bits
    typedef logic [2:0] lc3b_reg;

    // ROB tag / entry address
    typedef logic [TAG_WIDTH-1:0] lc3b_rob_addr;

    // One reorder buffer entry as seen by the commit side
    typedef struct packed {
        logic                  busy;
        logic                  ready;
        lc3b_opcode            opcode;
        lc3b_reg               dest;
        logic                  predict;
        logic [DATA_WIDTH-1:0] value;
    } lc3b_rob_entry;

endpackage

// File: rtl/reorder_buffer.sv
// ----------------------------------------------------------------------------
// reorder_buffer
//   Circular in-order reorder buffer between issue/CDB and commit.
//   Issue allocates one entry per instruction at the tail, the CDB fills
//   results in by tag, and commit pops the head once it is ready. A flush
//   from commit (mispredict) empties the buffer.
//
//   Optional feature macro: ROB_CDB_BYPASS_EN
//     defined     -> a CDB broadcast to a waiting head is visible on
//                    valid_out/value_out in the same cycle and may be popped.
//     not defined -> head result appears one cycle after the CDB write.
//
//   Ports
//     clk, rst_n                      clock, async active-low reset
//     alloc_valid/opcode/dest/
//     alloc_predict/alloc_ready       issue-side allocation request
//     alloc_addr                      tag handed out this cycle (= tail)
//     rob_full                        no free entry, issue stalls
//     cdb_valid/cdb_tag/cdb_value     common data bus broadcast
//     rd_tag_a/b, rd_ready_a/b,
//     rd_value_a/b                    operand lookup for reservation stations
//     valid_out, opcode_out, dest_out,
//     value_out, predict_out, rob_addr head entry presented to commit
//     rob_empty                       buffer holds no entries
//     RE                              commit pops the head
//     flush                           discard every entry
// ----------------------------------------------------------------------------
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int data_width = 16,
    parameter int tag_width  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  alloc_valid,
    input  lc3b_opcode            alloc_opcode,
    input  lc3b_reg               alloc_dest,
    input  logic                  alloc_predict,
    input  logic                  alloc_ready,
    output logic [tag_width-1:0]  alloc_addr,
    output logic                  rob_full,

    input  logic                  cdb_valid,
    input  logic [tag_width-1:0]  cdb_tag,
    input  logic [data_width-1:0] cdb_value,

    input  logic [tag_width-1:0]  rd_tag_a,
    input  logic [tag_width-1:0]  rd_tag_b,
    output logic                  rd_ready_a,
    output logic                  rd_ready_b,
    output logic [data_width-1:0] rd_value_a,
    output logic [data_width-1:0] rd_value_b,

    output logic                  valid_out,
    output lc3b_opcode            opcode_out,
    output lc3b_reg               dest_out,
    output logic [data_width-1:0] value_out,
    output logic                  predict_out,
    output logic [tag_width-1:0]  rob_addr,
    output logic                  rob_empty,

    input  logic                  RE,
    input  logic                  flush
);

    localparam int DEPTH = 1 << tag_width;

    // count is one bit wider than a tag so "full" (== DEPTH) is representable
    localparam logic [tag_width:0] FULL_COUNT = {1'b1, {tag_width{1'b0}}};

    logic                  busy_q    [DEPTH];
    logic                  ready_q   [DEPTH];
    lc3b_opcode            opcode_q  [DEPTH];
    lc3b_reg               dest_q    [DEPTH];
    logic                  predict_q [DEPTH];
    logic [data_width-1:0] value_q   [DEPTH];

    logic [tag_width-1:0]  head_q;
    logic [tag_width-1:0]  tail_q;
    logic [tag_width:0]    count_q;

    logic                  alloc_accept;
    logic                  pop_accept;
    logic                  cdb_write;
    logic                  head_ready;
    logic                  bypass_hit;

    // Occupancy flags decode the registered count only, so an alloc while
    // full is refused even when commit frees an entry in the same cycle.
    assign rob_full   = (count_q == FULL_COUNT);
    assign rob_empty  = (count_q == '0);
    assign alloc_addr = tail_q;
    assign rob_addr   = head_q;

    // The head may be completed either from storage or, when the bypass is
    // built in, directly from a CDB broadcast aimed at the waiting head.
`ifdef ROB_CDB_BYPASS_EN
    assign bypass_hit = busy_q[head_q] & ~ready_q[head_q] &
                        cdb_valid & (cdb_tag == head_q);
`else
    assign bypass_hit = 1'b0;
`endif

    assign head_ready  = busy_q[head_q] & (ready_q[head_q] | bypass_hit);
    assign valid_out   = head_ready;
    assign opcode_out  = opcode_q[head_q];
    assign dest_out    = dest_q[head_q];
    assign predict_out = predict_q[head_q];
    assign value_out   = bypass_hit ? cdb_value : value_q[head_q];

    assign alloc_accept = alloc_valid & ~rob_full;
    assign pop_accept   = RE & valid_out;

    // A CDB result only lands in an occupied entry; if it names the slot
    // being allocated this cycle the fresh allocation takes precedence.
    assign cdb_write = cdb_valid & busy_q[cdb_tag] &
                       ~(alloc_accept & (cdb_tag == tail_q));

    // Operand lookups read stored state only; reservation stations snoop
    // the CDB themselves, so no forwarding is done here.
    assign rd_ready_a = ready_q[rd_tag_a];
    assign rd_value_a = value_q[rd_tag_a];
    assign rd_ready_b = ready_q[rd_tag_b];
    assign rd_value_b = value_q[rd_tag_b];

    // Entry array, pointers and count. Flush outranks everything else that
    // cycle. Within a normal cycle the pop is applied last so a CDB write
    // to the popped head cannot leave it marked ready after it is freed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]    <= 1'b0;
                ready_q[i]   <= 1'b0;
                opcode_q[i]  <= op_br;
                dest_q[i]    <= '0;
                predict_q[i] <= 1'b0;
                value_q[i]   <= '0;
            end
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
            end
        end else begin
            if (cdb_write) begin
                value_q[cdb_tag] <= cdb_value;
                ready_q[cdb_tag] <= 1'b1;
            end
            if (alloc_accept) begin
                busy_q[tail_q]    <= 1'b1;
                ready_q[tail_q]   <= alloc_ready;
                opcode_q[tail_q]  <= alloc_opcode;
                dest_q[tail_q]    <= alloc_dest;
                predict_q[tail_q] <= alloc_predict;
                value_q[tail_q]   <= '0;
                tail_q            <= tail_q + 1'b1;
            end
            if (pop_accept) begin
                busy_q[head_q]  <= 1'b0;
                ready_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            count_q <= count_q + {{tag_width{1'b0}}, alloc_accept}
                               - {{tag_width{1'b0}}, pop_accept};
        end
    end

endmodule
